// File: rtl/rocc_pkg.sv
// Shared types and constants for the RoCC neurosynapse accelerator datapath.
// Holds the writeback state type, destination tag layout and decode opcodes.
package rocc_pkg;

  localparam int RD_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic            xd;
  } rocc_tag_t;

  // funct7 opcodes recognised by the decode stage
  localparam logic [6:0] FUNCT7_SYN_LOAD    = 7'd0;
  localparam logic [6:0] FUNCT7_SYN_INTEG   = 7'd1;
  localparam logic [6:0] FUNCT7_NEURON_FIRE = 7'd2;
  localparam logic [6:0] FUNCT7_STATUS      = 7'd3;

endpackage

// File: rtl/rocc_tag_fifo.sv
// Destination-tag FIFO between decode and writeback; power-of-two depth,
// pointers wrap naturally. Push is refused when full even if a pop coincides.
module rocc_tag_fifo
  import rocc_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = rocc_tag_t
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  T                       din_i,
  input  logic                   pop_i,
  output T                       dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T                mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: only entries behind the write pointer are read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/rocc_resp_writeback.sv
// RoCC response writeback: pairs operation-unit results with decoded tags and
// holds each response until the core accepts it. Macro ROCC_WB_PERF_CNT_EN adds perf counters.
//
// state | meaning
// IDLE  | no response pending toward the core
// RESP  | resp_valid asserted, response held until resp_ready
module rocc_resp_writeback
  import rocc_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int RES_WIDTH  = 32,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tag_valid,
  output logic                  tag_ready,
  input  logic [RD_W-1:0]       tag_rd,
  input  logic                  tag_xd,
  input  logic [RES_WIDTH-1:0]  op_result,
  input  logic                  op_output_STB,
  output logic                  output_module_BUSY,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [RD_W-1:0]       resp_rd,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  acc_busy
`ifdef ROCC_WB_PERF_CNT_EN
  ,
  output logic [31:0]           perf_resp_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);

  wb_state_t                  state_q;
  logic                       resp_valid_q;
  logic [RD_W-1:0]            resp_rd_q;
  logic [DATA_WIDTH-1:0]      resp_data_q;
  logic [DATA_WIDTH-1:0]      resp_data_d;

  rocc_tag_t                  tag_in;
  rocc_tag_t                  head_tag;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [$clog2(TAG_DEPTH):0] fifo_count;
  logic                       xfer;

  assign tag_in = '{rd: tag_rd, xd: tag_xd};

  rocc_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .T     (rocc_tag_t)
  ) u_tag_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (tag_valid),
    .din_i   (tag_in),
    .pop_i   (xfer),
    .dout_o  (head_tag),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // BUSY follows resp_ready combinationally so a held response can be
  // replaced in the same cycle it is accepted.
  assign output_module_BUSY = fifo_empty || (state_q == RESP && !resp_ready);
  assign xfer               = op_output_STB && !output_module_BUSY;
  assign tag_ready          = !fifo_full;
  assign acc_busy           = (fifo_count != '0) || (state_q == RESP);
  assign resp_data_d        = DATA_WIDTH'(op_result);

  assign resp_valid = resp_valid_q;
  assign resp_rd    = resp_rd_q;
  assign resp_data  = resp_data_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      resp_rd_q    <= '0;
      resp_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer && head_tag.xd) begin
            resp_rd_q    <= head_tag.rd;
            resp_data_q  <= resp_data_d;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            if (xfer && head_tag.xd) begin
              resp_rd_q   <= head_tag.rd;
              resp_data_q <= resp_data_d;
            end else begin
              resp_valid_q <= 1'b0;
              state_q      <= IDLE;
            end
          end
        end
      endcase
    end
  end

`ifdef ROCC_WB_PERF_CNT_EN
  logic [31:0] perf_resp_cnt_q;
  logic [31:0] perf_stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_resp_cnt_q  <= '0;
      perf_stall_cnt_q <= '0;
    end else begin
      if (resp_valid_q && resp_ready)  perf_resp_cnt_q  <= perf_resp_cnt_q + 32'd1;
      if (resp_valid_q && !resp_ready) perf_stall_cnt_q <= perf_stall_cnt_q + 32'd1;
    end
  end

  assign perf_resp_cnt  = perf_resp_cnt_q;
  assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

// File: tb/tb_rocc_resp_writeback.sv
// Bench for rocc_resp_writeback: directed scenarios then random traffic,
// checked each cycle against a queue-based model of the writeback rules.
module tb_rocc_resp_writeback;

  localparam int DW = 64;
  localparam int RW = 32;
  localparam int TD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tag_valid = 1'b0;
  logic [4:0]    tag_rd = '0;
  logic          tag_xd = 1'b0;
  logic [RW-1:0] op_result = '0;
  logic          op_output_STB = 1'b0;
  logic          resp_ready = 1'b0;
  logic          tag_ready;
  logic          output_module_BUSY;
  logic          resp_valid;
  logic [4:0]    resp_rd;
  logic [DW-1:0] resp_data;
  logic          acc_busy;
`ifdef ROCC_WB_PERF_CNT_EN
  logic [31:0]   perf_resp_cnt;
  logic [31:0]   perf_stall_cnt;
`endif

  rocc_resp_writeback #(.DATA_WIDTH(DW), .RES_WIDTH(RW), .TAG_DEPTH(TD)) dut (
    .clk                (clk),
    .rst                (rst),
    .tag_valid          (tag_valid),
    .tag_ready          (tag_ready),
    .tag_rd             (tag_rd),
    .tag_xd             (tag_xd),
    .op_result          (op_result),
    .op_output_STB      (op_output_STB),
    .output_module_BUSY (output_module_BUSY),
    .resp_valid         (resp_valid),
    .resp_ready         (resp_ready),
    .resp_rd            (resp_rd),
    .resp_data          (resp_data),
    .acc_busy           (acc_busy)
`ifdef ROCC_WB_PERF_CNT_EN
    ,
    .perf_resp_cnt      (perf_resp_cnt),
    .perf_stall_cnt     (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rd;
    logic       xd;
  } tag_s;

  int            tests = 0;
  int            fails = 0;
  tag_s          q[$];
  bit            m_valid = 1'b0;
  logic [4:0]    m_rd = '0;
  logic [DW-1:0] m_data = '0;
  logic [4:0]    got_rd[$];
  logic [DW-1:0] got_data[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are set at the falling edge; check outputs, advance the model, clock once.
  task automatic cycle();
    bit   e_ready, e_busy, e_acc, xfer, push;
    tag_s head;
    #1;
    e_ready = (q.size() < TD);
    e_busy  = (q.size() == 0) || (m_valid && !resp_ready);
    e_acc   = (q.size() != 0) || m_valid;
    chk("tag_ready", 64'(tag_ready), 64'(e_ready));
    chk("busy", 64'(output_module_BUSY), 64'(e_busy));
    chk("acc_busy", 64'(acc_busy), 64'(e_acc));
    chk("resp_valid", 64'(resp_valid), 64'(m_valid));
    if (m_valid) begin
      chk("resp_rd", 64'(resp_rd), 64'(m_rd));
      chk("resp_data", resp_data, m_data);
      if (resp_ready && rst) begin
        got_rd.push_back(resp_rd);
        got_data.push_back(resp_data);
      end
    end
    if (!rst) begin
      q.delete();
      m_valid = 1'b0;
      m_rd    = '0;
      m_data  = '0;
    end else begin
      xfer = op_output_STB && !e_busy;
      push = tag_valid && e_ready;
      if (m_valid && resp_ready) m_valid = 1'b0;
      if (xfer) begin
        head = q.pop_front();
        if (head.xd) begin
          m_valid = 1'b1;
          m_rd    = head.rd;
          m_data  = {32'd0, op_result};
        end
      end
      if (push) q.push_back('{rd: tag_rd, xd: tag_xd});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_tag(input logic [4:0] rd, input logic xd);
    tag_valid = 1'b1;
    tag_rd    = rd;
    tag_xd    = xd;
    cycle();
    tag_valid = 1'b0;
  endtask

  initial begin
    // Reset from unknown state
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 64'(resp_valid), 64'd0);
    chk("rst_rd", 64'(resp_rd), 64'd0);
    chk("rst_data", resp_data, 64'd0);
    chk("rst_acc", 64'(acc_busy), 64'd0);
    chk("rst_tag_ready", 64'(tag_ready), 64'd1);
    chk("rst_busy", 64'(output_module_BUSY), 64'd1);
`ifdef ROCC_WB_PERF_CNT_EN
    chk("rst_perf_resp", 64'(perf_resp_cnt), 64'd0);
    chk("rst_perf_stall", 64'(perf_stall_cnt), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b1;

    // Single response
    push_tag(5'd5, 1'b1);
    op_result = 32'h0000_00AA; op_output_STB = 1'b1; resp_ready = 1'b1;
    cycle();
    op_output_STB = 1'b0;
    chk("t1_valid", 64'(resp_valid), 64'd1);
    chk("t1_rd", 64'(resp_rd), 64'd5);
    chk("t1_data", resp_data, 64'h0000_0000_0000_00AA);
    cycle();
    chk("t1_acc_after", 64'(acc_busy), 64'd0);

    // Backpressure holds the response and blocks the next result
    push_tag(5'd7, 1'b1);
    push_tag(5'd8, 1'b1);
    resp_ready = 1'b0; op_output_STB = 1'b1; op_result = 32'h1234;
    cycle();
    op_result = 32'h5678;
    repeat (5) cycle();
    chk("t2_held_data", resp_data, 64'h1234);
    chk("t2_held_busy", 64'(output_module_BUSY), 64'd1);
    resp_ready = 1'b1;
    cycle();
    op_output_STB = 1'b0;
    chk("t2_second_rd", 64'(resp_rd), 64'd8);
    chk("t2_second_data", resp_data, 64'h5678);
    cycle();

    // Full FIFO refuses a push even alongside a pop
    for (int i = 0; i < TD; i++) push_tag(5'(10 + i), 1'b1);
    #1 chk("t3_full", 64'(tag_ready), 64'd0);
    tag_valid = 1'b1; tag_rd = 5'd20; tag_xd = 1'b1;
    op_output_STB = 1'b1; op_result = 32'hA0;
    cycle();
    tag_valid = 1'b0;
    chk("t3_after_pop", 64'(tag_ready), 64'd1);
    repeat (4) cycle();
    op_output_STB = 1'b0;
    repeat (2) cycle();
    chk("t3_drained", 64'(acc_busy), 64'd0);

    // xd=0 result is dropped
    got_rd.delete(); got_data.delete();
    push_tag(5'd1, 1'b1);
    push_tag(5'd2, 1'b0);
    push_tag(5'd3, 1'b1);
    op_output_STB = 1'b1;
    op_result = 32'h11; cycle();
    op_result = 32'h22; cycle();
    op_result = 32'h33; cycle();
    op_output_STB = 1'b0;
    repeat (2) cycle();
    chk("t4_count", 64'(got_rd.size()), 64'd2);
    if (got_rd.size() == 2) begin
      chk("t4_rd0", 64'(got_rd[0]), 64'd1);
      chk("t4_data0", got_data[0], 64'h11);
      chk("t4_rd1", 64'(got_rd[1]), 64'd3);
      chk("t4_data1", got_data[1], 64'h33);
    end

    // STB with empty FIFO waits for a tag
    op_output_STB = 1'b1; op_result = 32'hBEEF;
    repeat (2) cycle();
    chk("t5_busy_empty", 64'(output_module_BUSY), 64'd1);
    chk("t5_no_resp", 64'(resp_valid), 64'd0);
    push_tag(5'd9, 1'b1);
    cycle();
    op_output_STB = 1'b0;
    chk("t5_rd", 64'(resp_rd), 64'd9);
    chk("t5_data", resp_data, 64'hBEEF);
    cycle();

    // Reset while a response is pending with tags queued
    repeat (3) push_tag(5'd4, 1'b1);
    resp_ready = 1'b0; op_output_STB = 1'b1; op_result = 32'h77;
    cycle();
    op_output_STB = 1'b0;
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    chk("t6_valid", 64'(resp_valid), 64'd0);
    chk("t6_acc", 64'(acc_busy), 64'd0);
    chk("t6_tag_ready", 64'(tag_ready), 64'd1);
`ifdef ROCC_WB_PERF_CNT_EN
    chk("t6_perf_resp", 64'(perf_resp_cnt), 64'd0);
    chk("t6_perf_stall", 64'(perf_stall_cnt), 64'd0);
`endif

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst           = ($urandom_range(0, 99) != 0);
      tag_valid     = $urandom_range(0, 1);
      tag_rd        = 5'($urandom);
      tag_xd        = ($urandom_range(0, 3) != 0);
      op_output_STB = $urandom_range(0, 1);
      op_result     = $urandom;
      resp_ready    = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
